life_grid_seq: RTL and testbench

Sequencer that runs Conway's Game of Life on a W x H toroidal grid held in internal registers. It time-multiplexes one 8-neighbour cell evaluator: one cell per clock, row-major, writing into a shadow grid. The whole grid is committed at the end of each generation. It sits between the host-side load/readback interface and the cell rule logic, and runs a requested number of generations per start.

---
 rtl/life_grid_seq_if.sv | 36 +++
 rtl/life_grid_seq.sv | 174 +++++++++++++++++
 tb/tb_life_grid_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/life_grid_seq_if.sv
// Host-side bus for the Life grid sequencer.
// Groups the load port, run control, readback port and status outputs.
//   load_en/load_addr/load_row : row write into the current grid (IDLE only)
//   start/gens                 : launch a run of gens generations
//   rd_addr/rd_row             : combinational readback of the current grid
//   busy/done/gen_count/stable : run status
// master = host side, slave = sequencer side.
interface life_grid_seq_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned H     = 8,
    parameter int unsigned GEN_W = 16
);
    localparam int unsigned AW = $clog2(H);

    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [W-1:0]     load_row;
    logic             start;
    logic [GEN_W-1:0] gens;
    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     rd_row;
    logic             busy;
    logic             done;
    logic [GEN_W-1:0] gen_count;
    logic             stable;

    modport master (
        output load_en, load_addr, load_row, start, gens, rd_addr,
        input  rd_row, busy, done, gen_count, stable
    );

    modport slave (
        input  load_en, load_addr, load_row, start, gens, rd_addr,
        output rd_row, busy, done, gen_count, stable
    );
endinterface

// File: rtl/life_grid_seq.sv
// Conway's Game of Life sequencer on a W x H toroidal grid.
// A single 8-neighbour evaluator walks the grid one cell per clock in
// row-major order (x fastest), writing a shadow grid; the shadow grid is
// committed to the visible grid at the end of every generation, so readback
// never shows a partially evaluated generation.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active low (clears both grids)
//   bus    : life_grid_seq_if.slave (load, start/gens, readback, status)
//
// Optional feature macro LIFE_STABLE_HALT_EN:
//   defined   - COMMIT compares the new generation with the current one and
//               ends the run early (stable=1) when nothing changed.
//   undefined - no comparator, stable tied 0, all generations always run.
module life_grid_seq #(
    parameter int unsigned W     = 8,
    parameter int unsigned H     = 8,
    parameter int unsigned GEN_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    life_grid_seq_if.slave  bus
);
    localparam int unsigned XW    = $clog2(W);
    localparam int unsigned YW    = $clog2(H);
    localparam int unsigned IW    = XW + YW;
    localparam int unsigned CELLS = W * H;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;

    logic [H-1:0][W-1:0] cur;
    logic [H-1:0][W-1:0] nxt;
    logic [IW-1:0]       idx;
    logic [GEN_W-1:0]    remaining;
    logic [GEN_W-1:0]    gen_count_q;
    logic                stable_q;

    // Cell coordinates and toroidal neighbours; W and H are powers of two,
    // so plain modular wrap of the narrow indices gives the torus.
    logic [XW-1:0] x, xm, xp;
    logic [YW-1:0] y, ym, yp;
    logic [3:0]    count_c;
    logic          cell_nx_c;
    logic          last_cell_c;
    logic          grid_same_c;

    assign x  = idx[XW-1:0];
    assign y  = idx[IW-1:XW];
    assign xm = x - XW'(1);
    assign xp = x + XW'(1);
    assign ym = y - YW'(1);
    assign yp = y + YW'(1);

    // Live neighbour count, 0..8, at 4 bits so 8 is representable.
    assign count_c = 4'(cur[ym][xm]) + 4'(cur[ym][x]) + 4'(cur[ym][xp])
                   + 4'(cur[y][xm])                   + 4'(cur[y][xp])
                   + 4'(cur[yp][xm]) + 4'(cur[yp][x]) + 4'(cur[yp][xp]);

    assign cell_nx_c   = (count_c == 4'd3) | (cur[y][x] & (count_c == 4'd2));
    assign last_cell_c = (idx == IW'(CELLS - 1));

`ifdef LIFE_STABLE_HALT_EN
    // Whole-grid equality: the generation just computed changed nothing.
    assign grid_same_c = (nxt == cur);
`else
    assign grid_same_c = 1'b0;
`endif

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    // Next state; busy/done are the registered image of the next state.
    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.gens == GEN_W'(0)) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (last_cell_c) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                if ((remaining == GEN_W'(1)) || grid_same_c) begin
                    state_nx = FIN;
                end else begin
                    state_nx = SCAN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx == SCAN) || (state_nx == COMMIT);
        done_nx = (state_nx == FIN);
    end

    // Grid storage, scan index and run counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= '0;
            nxt         <= '0;
            idx         <= '0;
            remaining   <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_en) begin
                        cur[bus.load_addr] <= bus.load_row;
                    end
                    if (bus.start) begin
                        remaining   <= bus.gens;
                        gen_count_q <= '0;
                        stable_q    <= 1'b0;
                        idx         <= '0;
                    end
                end
                SCAN: begin
                    nxt[y][x] <= cell_nx_c;
                    // Wraps to 0 after the last cell (CELLS is a power of two).
                    idx       <= idx + IW'(1);
                end
                COMMIT: begin
                    cur         <= nxt;
                    gen_count_q <= gen_count_q + GEN_W'(1);
                    remaining   <= remaining - GEN_W'(1);
                    idx         <= '0;
                    if (grid_same_c) begin
                        stable_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_row    = cur[bus.rd_addr];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.gen_count = gen_count_q;
    assign bus.stable    = stable_q;

endmodule

// File: tb/tb_life_grid_seq.sv
// Directed bench for life_grid_seq. Each run pushes its expected outcome
// (latency, gen_count, stable, final grid) from a software Life model into a
// scoreboard queue; the entry is popped and compared when done is seen.
module tb_life_grid_seq;
    localparam int unsigned W     = 8;
    localparam int unsigned H     = 8;
    localparam int unsigned GEN_W = 16;
    localparam int unsigned AW    = $clog2(H);

    typedef logic [H-1:0][W-1:0] grid_t;

    typedef struct packed {
        logic [31:0]      lat;
        logic [GEN_W-1:0] gc;
        logic             st;
        logic             bs;
        grid_t            grid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    grid_t model;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    life_grid_seq_if #(.W(W), .H(H), .GEN_W(GEN_W)) bus ();

    life_grid_seq #(.W(W), .H(H), .GEN_W(GEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic grid_t life_step(input grid_t g);
        grid_t r;
        int n;
        for (int yy = 0; yy < int'(H); yy++) begin
            for (int xx = 0; xx < int'(W); xx++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dy != 0 || dx != 0) begin
                            n += int'(g[(yy + dy + int'(H)) % int'(H)][(xx + dx + int'(W)) % int'(W)]);
                        end
                    end
                end
                r[yy][xx] = (n == 3) || (g[yy][xx] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grid(input string tag, input grid_t g);
        for (int r = 0; r < int'(H); r++) begin
            @(negedge clk);
            bus.rd_addr = AW'(r);
            #1;
            chk($sformatf("%s_row%0d", tag, r), 64'(bus.rd_row), 64'(g[r]));
        end
    endtask

    task automatic load_grid(input grid_t g);
        for (int r = 0; r < int'(H); r++) begin
            @(negedge clk);
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(r);
            bus.load_row  = g[r];
        end
        @(negedge clk);
        bus.load_en = 1'b0;
        model = g;
    endtask

    // Runs n generations; inject>0 pulses start/load into row 0 at that
    // cycle offset while the sequencer is busy.
    task automatic run(input string tag, input int n, input int inject);
        exp_t  e;
        grid_t g, nx;
        int    gc;
        logic  st;
        int    k;
        logic  done_seen;
        logic  busy_seen;

        g  = model;
        gc = 0;
        st = 1'b0;
        for (int i = 0; i < n; i++) begin
            nx = life_step(g);
            gc++;
`ifdef LIFE_STABLE_HALT_EN
            if (nx == g) begin
                st = 1'b1;
                break;
            end
`endif
            g = nx;
        end
        e.lat  = 32'(1 + gc * int'(W * H + 1));
        e.gc   = GEN_W'(gc);
        e.st   = st;
        e.bs   = (n != 0);
        e.grid = g;
        sb.push_back(e);
        model = g;

        @(negedge clk);
        bus.start = 1'b1;
        bus.gens  = GEN_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.gens  = '0;
        k = 0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        while (k < int'(e.lat) + 50) begin
            if (inject > 0 && k == inject) begin
                bus.start     = 1'b1;
                bus.gens      = GEN_W'(5);
                bus.load_en   = 1'b1;
                bus.load_addr = '0;
                bus.load_row  = '1;
            end else if (inject > 0 && k == inject + 1) begin
                bus.start   = 1'b0;
                bus.gens    = '0;
                bus.load_en = 1'b0;
            end
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        bus.start   = 1'b0;
        bus.load_en = 1'b0;

        e = sb.pop_front();
        chk({tag, "_done_seen"}, 64'(done_seen), 64'(1));
        chk({tag, "_latency"}, 64'(k + 1), 64'(e.lat));
        chk({tag, "_gen_count"}, 64'(bus.gen_count), 64'(e.gc));
        chk({tag, "_stable"}, 64'(bus.stable), 64'(e.st));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
        chk({tag, "_busy_seen"}, 64'(busy_seen), 64'(e.bs));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
        check_grid(tag, e.grid);
    endtask

    initial begin
        grid_t g;

        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_row  = '0;
        bus.start     = 1'b0;
        bus.gens      = '0;
        bus.rd_addr   = '0;
        model         = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_gen_count", 64'(bus.gen_count), 64'(0));
        chk("rst_stable", 64'(bus.stable), 64'(0));
        rst_n = 1'b1;
        check_grid("rst", '0);

        // Blinker: horizontal bar on row 3 becomes vertical bar in column 3.
        g = '0;
        g[3] = 8'b0001_1100;
        load_grid(g);
        run("blinker", 1, 0);
        chk("blinker_row2_const", 64'(model[2]), 64'(8'b0000_1000));

        // Zero generations: immediate done, grid and count untouched.
        run("gens0", 0, 0);

        // Host writes/starts while busy must be ignored.
        run("busyprot", 2, 10);

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.start = 1'b1;
        bus.gens  = GEN_W'(3);
        @(negedge clk);
        bus.start = 1'b0;
        bus.gens  = '0;
        repeat (20) @(negedge clk);
        chk("midrst_busy_before", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        chk("midrst_gen_count", 64'(bus.gen_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model = '0;
        check_grid("midrst", '0);

        // Glider returns to its start position after 32 generations.
        g = '0;
        g[0] = 8'b0000_0010;
        g[1] = 8'b0000_0100;
        g[2] = 8'b0000_0111;
        load_grid(g);
        run("glider", 32, 0);

        // Still life: block halts early when stable detection is built in.
        g = '0;
        g[1] = 8'b0000_0110;
        g[2] = 8'b0000_0110;
        load_grid(g);
        run("block", 100, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
